pim_bank_array: RTL and testbench

- Parametrised successor to the depth-split PIM memory.
- Holds 2^BANK_SEL_W banks of PIM atoms behind one request port. Each atom is 2^ATOM_ADDR_W words by DATA_W bits.
- Supports WRITE, READ and an in-memory accumulate operation (ACC, read-modify-write).
- Adds a valid/ready handshake, a registered bank-select output mux, response valid, and hazard stalling for back-to-back read-modify-write traffic.

---
 rtl/pim_bank_pkg.sv | 27 ++
 rtl/pim_bank_atom.sv | 42 ++++
 rtl/pim_bank_array.sv | 116 +++++++++++
 tb/tb_pim_bank_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_bank_pkg.sv
// Shared definitions for the banked PIM array: op codes, default geometry and
// the S1 stage record carried from request decode to write-back/response.
package pim_bank_pkg;

  localparam int PIM_DATA_W      = 40;
  localparam int PIM_ATOM_ADDR_W = 7;
  localparam int PIM_BANK_SEL_W  = 2;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ACC   = 2'b11;

  // Sized for the default geometry; the top-level parameters default to these.
  typedef struct packed {
    logic                       valid;
    logic [1:0]                 op;
    logic [PIM_BANK_SEL_W-1:0]  bank;
    logic [PIM_ATOM_ADDR_W-1:0] word;
    logic [PIM_DATA_W-1:0]      data;
  } s1_rec_t;

  function automatic logic is_rsp_op(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_ACC);
  endfunction

endpackage

// File: rtl/pim_bank_atom.sv
// One PIM atom: synchronous read-first RAM with 1-cycle read latency on the
// request port, plus a write-back port used by the accumulate stage.
module pim_bank_atom
  import pim_bank_pkg::*;
#(
  parameter int DATA_W = PIM_DATA_W,
  parameter int ADDR_W = PIM_ATOM_ADDR_W
) (
  input  logic              clk,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;

  // The write-back port lets an S1 accumulate retire while S0 keeps using the
  // request port for another word of the same bank; the top never lets both
  // target the same word in one cycle.
  always_ff @(posedge clk) begin
    if (a_en) begin
      a_rdata_q <= mem_q[a_addr];
      if (a_we) begin
        mem_q[a_addr] <= a_wdata;
      end
    end
    if (wb_en) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  assign a_rdata = a_rdata_q;

endmodule

// File: rtl/pim_bank_array.sv
// Banked PIM array: valid/ready request port, 3-stage WRITE/READ/ACC pipeline,
// same-address stall behind an in-flight accumulate, registered response mux.
module pim_bank_array
  import pim_bank_pkg::*;
#(
  parameter int DATA_W      = PIM_DATA_W,
  parameter int ATOM_ADDR_W = PIM_ATOM_ADDR_W,
  parameter int BANK_SEL_W  = PIM_BANK_SEL_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [BANK_SEL_W+ATOM_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]             req_data,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [BANK_SEL_W-1:0]         rsp_bank,
  output logic                          busy
);

  localparam int NUM_BANKS = 1 << BANK_SEL_W;
  localparam int ADDR_W    = BANK_SEL_W + ATOM_ADDR_W;

  // Handshake: a request transfers in any cycle where req_valid && req_ready.
  // req_ready drops only in reset or for a non-NOP request hitting the address
  // of an accumulate currently in S1. Responses are never backpressured.

  logic [BANK_SEL_W-1:0]            req_bank;
  logic [ATOM_ADDR_W-1:0]           req_word;
  logic                             hazard;
  logic                             accept;
  logic                             wb_en;
  logic [DATA_W-1:0]                s1_rdata;
  logic [DATA_W-1:0]                acc_sum;
  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;

  s1_rec_t                s1_d, s1_q;
  logic                   s2_valid_d, s2_valid_q;
  logic                   rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0]      rsp_data_d, rsp_data_q;
  logic [BANK_SEL_W-1:0]  rsp_bank_d, rsp_bank_q;

  assign req_bank = req_addr[ADDR_W-1:ATOM_ADDR_W];
  assign req_word = req_addr[ATOM_ADDR_W-1:0];

  always_comb begin
    hazard    = s1_q.valid && (s1_q.op == OP_ACC) && req_valid &&
                (req_op != OP_NOP) && ({s1_q.bank, s1_q.word} == req_addr);
    req_ready = rst_n && !hazard;
    accept    = req_valid && req_ready && (req_op != OP_NOP);
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    pim_bank_atom #(
      .DATA_W (DATA_W),
      .ADDR_W (ATOM_ADDR_W)
    ) u_atom (
      .clk     (clk),
      .a_en    (accept && (req_bank == BANK_SEL_W'(g))),
      .a_we    (accept && (req_bank == BANK_SEL_W'(g)) && (req_op == OP_WRITE)),
      .a_addr  (req_word),
      .a_wdata (req_data),
      .a_rdata (bank_rdata[g]),
      .wb_en   (wb_en && (s1_q.bank == BANK_SEL_W'(g))),
      .wb_addr (s1_q.word),
      .wb_data (acc_sum)
    );
  end

  // Write-back is gated by rst_n so a reset during S1 leaves memory untouched.
  always_comb begin
    s1_rdata = bank_rdata[s1_q.bank];
    acc_sum  = s1_rdata + s1_q.data;
    wb_en    = s1_q.valid && (s1_q.op == OP_ACC) && rst_n;
  end

  always_comb begin
    s1_d.valid  = accept;
    s1_d.op     = req_op;
    s1_d.bank   = req_bank;
    s1_d.word   = req_word;
    s1_d.data   = req_data;
    s2_valid_d  = s1_q.valid;
    rsp_valid_d = s1_q.valid && is_rsp_op(s1_q.op);
    rsp_data_d  = rsp_data_q;
    rsp_bank_d  = rsp_bank_q;
    if (rsp_valid_d) begin
      rsp_data_d = (s1_q.op == OP_ACC) ? acc_sum : s1_rdata;
      rsp_bank_d = s1_q.bank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_bank_q  <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_bank_q  <= rsp_bank_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_bank  = rsp_bank_q;
  assign busy      = s1_q.valid | s2_valid_q;

endmodule

// File: tb/tb_pim_bank_array.sv
// Self-checking bench for pim_bank_array: directed scenarios then random
// traffic, checked every cycle against a transaction-level memory model.
module tb_pim_bank_array;
  import pim_bank_pkg::*;

  localparam int DATA_W      = 40;
  localparam int ATOM_ADDR_W = 7;
  localparam int BANK_SEL_W  = 2;
  localparam int ADDR_W      = BANK_SEL_W + ATOM_ADDR_W;
  localparam int EXP_W       = BANK_SEL_W + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [1:0]            req_op = 2'b00;
  logic [ADDR_W-1:0]     req_addr = '0;
  logic [DATA_W-1:0]     req_data = '0;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic [BANK_SEL_W-1:0] rsp_bank;
  logic                  busy;

  always #5 clk = ~clk;

  pim_bank_array #(
    .DATA_W      (DATA_W),
    .ATOM_ADDR_W (ATOM_ADDR_W),
    .BANK_SEL_W  (BANK_SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_bank  (rsp_bank),
    .busy      (busy)
  );

  // ---------------- reference model state ----------------
  logic [DATA_W-1:0] mem_m [1 << ADDR_W];
  logic [EXP_W-1:0]  exp_q[$];
  int                due_q[$];
  int                cyc = 0;
  int                vectors = 0;
  int                miscompares = 0;
  bit                occ1 = 1'b0;
  bit                occ2 = 1'b0;
  bit                pa_v = 1'b0;
  logic [ADDR_W-1:0] pa_addr = '0;
  logic [DATA_W-1:0] pa_old = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [1:0] op,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
  endtask

  // One cycle: sample mid-cycle, score, advance model, step to posedge+1.
  task automatic tick(output bit accepted);
    logic [EXP_W-1:0]  e;
    logic [DATA_W-1:0] nv;
    bit                exp_ready;
    @(negedge clk);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, e[DATA_W-1:0]);
      check("rsp_bank", rsp_bank, e[EXP_W-1:DATA_W]);
    end else begin
      check("rsp_idle", rsp_valid, 0);
    end
    check("busy", busy, occ1 | occ2);
    exp_ready = rst_n && !(pa_v && req_valid && (req_op != OP_NOP) && (req_addr == pa_addr));
    check("req_ready", req_ready, exp_ready);
    accepted = rst_n && req_valid && req_ready;
    if (!rst_n) begin
      if (pa_v) mem_m[pa_addr] = pa_old;
      exp_q.delete();
      due_q.delete();
      occ1 = 1'b0;
      occ2 = 1'b0;
      pa_v = 1'b0;
    end else begin
      occ2 = occ1;
      occ1 = accepted && (req_op != OP_NOP);
      pa_v = accepted && (req_op == OP_ACC);
      if (accepted) begin
        pa_addr = req_addr;
        pa_old  = mem_m[req_addr];
        case (req_op)
          OP_WRITE: mem_m[req_addr] = req_data;
          OP_READ: begin
            exp_q.push_back({req_addr[ADDR_W-1:ATOM_ADDR_W], mem_m[req_addr]});
            due_q.push_back(cyc + 2);
          end
          OP_ACC: begin
            nv = mem_m[req_addr] + req_data;
            mem_m[req_addr] = nv;
            exp_q.push_back({req_addr[ADDR_W-1:ATOM_ADDR_W], nv});
            due_q.push_back(cyc + 2);
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    drive(1'b1, op, a, d);
    for (int i = 0; i < 8; i++) begin
      tick(acc);
      if (acc) break;
      stalls++;
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    drive(1'b0, OP_NOP, '0, '0);
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  // ---------------- stimulus ----------------
  logic [ADDR_W-1:0] pool [6] = '{9'h005, 9'h006, 9'h085, 9'h105, 9'h1FF, 9'h000};

  initial begin
    int                st;
    bit                acc;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] last_a;
    logic [1:0]        op;
    logic [DATA_W-1:0] d;

    // Reset state
    drive(1'b1, OP_READ, 9'h005, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_bank", rsp_bank, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    drive(1'b0, OP_NOP, '0, '0);
    rst_n = 1'b1;
    idle(1);

    // Write then read next cycle
    send(OP_WRITE, 9'h005, 40'h12_3456_789A, st);
    send(OP_READ,  9'h005, '0, st);
    idle(3);

    // Bank isolation
    send(OP_WRITE, 9'h085, 40'hAA, st);
    send(OP_WRITE, 9'h105, 40'hBB, st);
    send(OP_READ,  9'h085, '0, st);
    send(OP_READ,  9'h105, '0, st);
    send(OP_READ,  9'h005, '0, st);
    idle(3);

    // Back-to-back ACC to one address: exactly one stall
    send(OP_WRITE, 9'h010, 40'd7, st);
    send(OP_ACC,   9'h010, 40'd1, st);
    check("acc1_stalls", st, 0);
    send(OP_ACC,   9'h010, 40'd1, st);
    check("acc2_stalls", st, 1);
    send(OP_READ,  9'h010, '0, st);
    idle(3);

    // Accumulate wrap-around
    send(OP_WRITE, 9'h020, 40'hFF_FFFF_FFFF, st);
    idle(1);
    send(OP_ACC,   9'h020, 40'd2, st);
    idle(1);
    send(OP_READ,  9'h020, '0, st);
    idle(3);

    // Reset while an ACC sits in S1
    send(OP_WRITE, 9'h030, 40'd5, st);
    send(OP_ACC,   9'h030, 40'd3, st);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    send(OP_READ,  9'h030, '0, st);
    idle(3);

    // Streaming reads to distinct addresses
    send(OP_READ, 9'h005, '0, st); check("stream0_stalls", st, 0);
    send(OP_READ, 9'h085, '0, st); check("stream1_stalls", st, 0);
    send(OP_READ, 9'h105, '0, st); check("stream2_stalls", st, 0);
    send(OP_READ, 9'h010, '0, st); check("stream3_stalls", st, 0);
    idle(3);

    // Random traffic over a small address pool to provoke hazards
    for (int i = 0; i < 6; i++) send(OP_WRITE, pool[i], DATA_W'({$urandom(), $urandom()}), st);
    last_a = pool[0];
    for (int i = 0; i < 600; i++) begin
      a  = ($urandom_range(0, 1) != 0) ? last_a : pool[$urandom_range(0, 5)];
      op = 2'($urandom_range(0, 3));
      d  = DATA_W'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) d = DATA_W'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 7) != 0, op, a, d);
      tick(acc);
      last_a = a;
    end
    rst_n = 1'b1;
    idle(4);
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
